// File: rtl/script_tx_arbiter_if.sv
// script_tx_arbiter_if: byte stream handshake between the arbiter and the UART transmitter.
interface script_tx_arbiter_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    modport master (output tx_valid, tx_data, input tx_ready);
    modport slave  (input tx_valid, tx_data, output tx_ready);
endinterface

// File: rtl/script_tx_arbiter.sv
// script_tx_arbiter: sends changed operate/target/game_state packets as one byte stream,
// fixed priority gs > tg > op, with an enforced inter-byte gap and a periodic target refresh.
module script_tx_arbiter #(
    parameter int GAP_CYCLES     = 16,
    parameter int REFRESH_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [7:0]                 data_operate,
    input  logic [7:0]                 data_target,
    input  logic [7:0]                 data_game_state,
    script_tx_arbiter_if.master        tx,
    output logic                       busy
);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] REF_LAST = 32'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t      state;
    logic [7:0]  last_op, last_tg, last_gs;
    logic        pend_op, pend_tg, pend_gs;
    logic [31:0] gap_cnt, ref_cnt;
    logic        req_op, req_tg, req_gs;
    logic        grant_op, grant_tg, grant_gs, ref_hit;

    // A live change counts as a request so an idle arbiter grants with one cycle of latency.
    assign req_gs   = pend_gs | (data_game_state != last_gs);
    assign req_tg   = pend_tg | (data_target != last_tg);
    assign req_op   = pend_op | (data_operate != last_op);
    assign grant_gs = (state == IDLE) & req_gs;
    assign grant_tg = (state == IDLE) & req_tg & ~req_gs;
    assign grant_op = (state == IDLE) & req_op & ~req_gs & ~req_tg;
    assign ref_hit  = (REFRESH_CYCLES != 0) && (ref_cnt == REF_LAST);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state       <= IDLE;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
            busy        <= 1'b0;
            last_op     <= 8'h00;
            last_tg     <= 8'h00;
            last_gs     <= 8'h00;
            pend_op     <= 1'b0;
            pend_tg     <= 1'b0;
            pend_gs     <= 1'b0;
            gap_cnt     <= '0;
            ref_cnt     <= '0;
        end else begin
            pend_gs <= grant_gs ? 1'b0 : req_gs;
            pend_tg <= (grant_tg ? 1'b0 : req_tg) | ref_hit;
            pend_op <= grant_op ? 1'b0 : req_op;
            ref_cnt <= (ref_hit || REFRESH_CYCLES == 0) ? '0 : ref_cnt + 32'd1;
            if (grant_gs) last_gs <= data_game_state;
            if (grant_tg) last_tg <= data_target;
            if (grant_op) last_op <= data_operate;
            case (state)
                IDLE: if (grant_gs | grant_tg | grant_op) begin
                    tx.tx_data  <= grant_gs ? data_game_state : grant_tg ? data_target : data_operate;
                    tx.tx_valid <= 1'b1;
                    busy        <= 1'b1;
                    state       <= SEND;
                end
                SEND: if (tx.tx_ready) begin
                    tx.tx_valid <= 1'b0;
                    gap_cnt     <= '0;
                    state       <= GAP;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    gap_cnt <= gap_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
